rr_grant_scheduler: RTL and testbench

// - Round-robin scheduler that shares one resource among NUM_REQ requesters.
// - Holds the grant for a whole transaction and releases it on done_i, on requester drop, or on timeout.
// - Drives a one-hot grant vector through a demultiplexer instance (data_i=grant_valid_o, select_i=grant_idx_o).
// - Sits in front of shared core resources, e.g. the memory port or a shared functional unit.
//

---
 rtl/rr_grant_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_rr_grant_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_scheduler.sv
// ---------------------------------------------------------------------------
// rr_grant_demux
//   One-to-N demultiplexer: routes data_i onto the output bit chosen by
//   select_i. Select values at or above N give an all-zero output, so the
//   result has at most one bit set.
//
//   data_i    in   1        bit to route
//   select_i  in   SEL_W    destination index
//   data_o    out  N        routed vector
// ---------------------------------------------------------------------------
module rr_grant_demux #(
    parameter int N     = 8,
    parameter int SEL_W = 3
) (
    input  logic             data_i,
    input  logic [SEL_W-1:0] select_i,
    output logic [N-1:0]     data_o
);

    always_comb begin
        data_o = '0;
        for (int i = 0; i < N; i++) begin
            if (select_i == SEL_W'(i)) begin
                data_o[i] = data_i;
            end
        end
    end

endmodule

// ---------------------------------------------------------------------------
// rr_grant_scheduler
//   Round-robin scheduler sharing one resource among NUM_REQ requesters.
//   A grant is held for a whole transaction and released on done_i, on the
//   grantee dropping its request, or when the hold timer expires. On a
//   release the next grantee is chosen in the same cycle, so back-to-back
//   grants have no idle bubble.
//
//   clk_i          in   1         clock, rising edge
//   arst_ni        in   1         asynchronous active-low reset
//   req_i          in   NUM_REQ   request levels
//   done_i         in   1         grantee finished (ignored while idle)
//   grant_o        out  NUM_REQ   one-hot grant, zero when idle
//   grant_idx_o    out  IDX_W     index of the current grantee
//   grant_valid_o  out  1         a grant is active
//   timeout_o      out  1         one-cycle pulse: grant revoked by timer
//
//   state | meaning
//   IDLE  | no grant active, arbitrate from r_ptr every cycle
//   BUSY  | grant active, hold timer running
// ---------------------------------------------------------------------------
module rr_grant_scheduler #(
    parameter int NUM_REQ  = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       done_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
    output logic                       grant_valid_o,
    output logic                       timeout_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [IDX_W-1:0]   w_grant_idx_nxt;
    logic               r_grant_valid;
    logic               w_grant_valid_nxt;
    logic               r_timeout;
    logic               w_timeout_nxt;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [CNT_W-1:0]   w_hold_cnt_nxt;

    logic [NUM_REQ-1:0] w_grant_vec;
    logic [NUM_REQ-1:0] w_cand;
    logic [IDX_W-1:0]   w_start;
    logic [IDX_W-1:0]   w_ptr_rel;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_hit;
    logic               w_done_rel;
    logic               w_drop_rel;
    logic               w_tmo_rel;
    logic               w_release;

    // -----------------------------------------------------------------------
    // Grant vector decode
    // -----------------------------------------------------------------------
    rr_grant_demux #(
        .N     (NUM_REQ),
        .SEL_W (IDX_W)
    ) u_grant_demux (
        .data_i   (r_grant_valid),
        .select_i (r_grant_idx),
        .data_o   (w_grant_vec)
    );

    // -----------------------------------------------------------------------
    // Release conditions
    // -----------------------------------------------------------------------
    assign w_done_rel = done_i;
    assign w_drop_rel = ~req_i[r_grant_idx];
    assign w_tmo_rel  = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign w_release  = (r_state == ST_BUSY) & (w_done_rel | w_drop_rel | w_tmo_rel);

    // Pointer after a release; explicit wrap so NUM_REQ need not be 2^n.
    assign w_ptr_rel = (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                             : r_grant_idx + IDX_W'(1);

    // -----------------------------------------------------------------------
    // Winner search. The current grantee is masked out of the candidates
    // (grant vector is zero while idle, so idle arbitration sees raw req_i).
    // While busy the scan starts from the post-release pointer; the result
    // is only used when a release actually happens.
    // -----------------------------------------------------------------------
    assign w_cand  = req_i & ~w_grant_vec;
    assign w_start = (r_state == ST_BUSY) ? w_ptr_rel : r_ptr;

    // Two passes give the circular scan: first [start, NUM_REQ-1], then the
    // wrapped part [0, start-1], which is only reached when pass one missed.
    always_comb begin
        w_win_hit = 1'b0;
        w_win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_win_hit && w_cand[i] && (IDX_W'(i) >= w_start)) begin
                w_win_hit = 1'b1;
                w_win_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_win_hit && w_cand[i]) begin
                w_win_hit = 1'b1;
                w_win_idx = IDX_W'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_grant_idx_nxt   = r_grant_idx;
        w_grant_valid_nxt = r_grant_valid;
        w_hold_cnt_nxt    = r_hold_cnt;
        w_timeout_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_win_hit) begin
                    w_state_nxt       = ST_BUSY;
                    w_grant_idx_nxt   = w_win_idx;
                    w_grant_valid_nxt = 1'b1;
                    w_hold_cnt_nxt    = '0;
                end
            end
            ST_BUSY: begin
                if (w_release) begin
                    w_ptr_nxt      = w_ptr_rel;
                    w_hold_cnt_nxt = '0;
                    // Timer pulse only when nothing else caused the release.
                    w_timeout_nxt  = w_tmo_rel & ~w_done_rel & ~w_drop_rel;
                    if (w_win_hit) begin
                        w_grant_idx_nxt = w_win_idx;
                    end else begin
                        w_state_nxt       = ST_IDLE;
                        w_grant_valid_nxt = 1'b0;
                    end
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt       = ST_IDLE;
                w_grant_valid_nxt = 1'b0;
                w_hold_cnt_nxt    = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_hold_cnt    <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_grant_idx   <= w_grant_idx_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

    assign grant_o       = w_grant_vec;
    assign grant_idx_o   = r_grant_idx;
    assign grant_valid_o = r_grant_valid;
    assign timeout_o     = r_timeout;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
module tb_rr_grant_scheduler;

    localparam int N  = 8;
    localparam int MH = 16;

    logic         clk_i   = 1'b0;
    logic         arst_ni = 1'b0;
    logic [N-1:0] req_i   = '0;
    logic         done_i  = 1'b0;
    logic [N-1:0] grant_o;
    logic [2:0]   grant_idx_o;
    logic         grant_valid_o;
    logic         timeout_o;

    rr_grant_scheduler #(
        .NUM_REQ  (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk_i         (clk_i),
        .arst_ni       (arst_ni),
        .req_i         (req_i),
        .done_i        (done_i),
        .grant_o       (grant_o),
        .grant_idx_o   (grant_idx_o),
        .grant_valid_o (grant_valid_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         valid;
        int           idx;
        logic [N-1:0] grant;
        logic         tmo;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: who holds the grant, for how many cycles, and where
    // the round-robin search starts next.
    int m_holder = -1;
    int m_held   = 0;
    int m_ptr    = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic bit_at(input logic [N-1:0] v, input int i);
        logic [2:0] s;
        s = 3'(i);
        return v[s];
    endfunction

    function automatic int pick(input logic [N-1:0] req, input int start, input int skip);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (bit_at(req, i) && i != skip) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] req, input logic done, output exp_t e);
        logic tmo;
        logic expired;
        tmo = 1'b0;
        if (m_holder < 0) begin
            m_holder = pick(req, m_ptr, -1);
            m_held   = 1;
        end else begin
            expired = (m_held == MH);
            if (done || !bit_at(req, m_holder) || expired) begin
                tmo      = expired && !done && bit_at(req, m_holder);
                m_ptr    = (m_holder + 1) % N;
                m_holder = pick(req, m_ptr, m_holder);
                m_held   = 1;
            end else begin
                m_held++;
            end
        end
        e.valid = (m_holder >= 0);
        e.idx   = (m_holder >= 0) ? m_holder : 0;
        e.grant = (m_holder >= 0) ? N'(1 << m_holder) : '0;
        e.tmo   = tmo;
    endtask

    // Called at a falling edge: drive inputs, queue the expected post-edge
    // outputs, and return at the next falling edge.
    task automatic step(input logic [N-1:0] req, input logic done);
        exp_t e;
        req_i  = req;
        done_i = done;
        model_step(req, done, e);
        exp_q.push_back(e);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #3;
        arst_ni = 1'b0;
        #1;
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_valid", 32'(grant_valid_o), 32'h0);
        chk("rst_timeout", 32'(timeout_o), 32'h0);
        exp_q.delete();
        req_i    = '0;
        done_i   = 1'b0;
        m_holder = -1;
        m_held   = 0;
        m_ptr    = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        arst_ni = 1'b1;
    endtask

    // Monitor: compares the DUT against the oldest queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_valid", 32'(grant_valid_o), 32'(e.valid));
                chk("sb_grant", 32'(grant_o), 32'(e.grant));
                chk("sb_timeout", 32'(timeout_o), 32'(e.tmo));
                if (e.valid) chk("sb_idx", 32'(grant_idx_o), 32'(e.idx));
            end
        end
    end

    initial begin : driver
        logic [N-1:0] rv;
        #1;
        chk("init_valid", 32'(grant_valid_o), 32'h0);
        chk("init_idx", 32'(grant_idx_o), 32'h0);
        chk("init_grant", 32'(grant_o), 32'h0);
        chk("init_timeout", 32'(timeout_o), 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        arst_ni = 1'b1;

        // No requests: stays idle
        repeat (6) step(8'h00, 1'b0);
        chk("idle_valid", 32'(grant_valid_o), 32'h0);

        // Single requester, done at cycle 3
        do_reset();
        step(8'h04, 1'b0);
        chk("single_grant", 32'(grant_o), 32'h04);
        chk("single_idx", 32'(grant_idx_o), 32'h2);
        step(8'h04, 1'b0);
        step(8'h04, 1'b0);
        step(8'h04, 1'b1);
        chk("single_release", 32'(grant_valid_o), 32'h0);
        step(8'h00, 1'b0);

        // All requesting, done every second cycle: 0..7,0 with no gap
        do_reset();
        for (int k = 0; k < 18; k++) begin
            step(8'hFF, (k % 2) == 1);
            chk("rr_valid", 32'(grant_valid_o), 32'h1);
            if (k % 2 == 1) chk("rr_seq", 32'(grant_idx_o), 32'(((k + 1) / 2) % N));
        end

        // Timeout and wrap to index 7
        do_reset();
        for (int k = 0; k < 17; k++) begin
            step(8'h81, 1'b0);
            if (k == 15) begin
                chk("hold_no_tmo", 32'(timeout_o), 32'h0);
                chk("hold_idx0", 32'(grant_idx_o), 32'h0);
            end
        end
        chk("tmo_pulse", 32'(timeout_o), 32'h1);
        chk("tmo_wrap_idx", 32'(grant_idx_o), 32'h7);
        step(8'h81, 1'b0);
        chk("tmo_one_cycle", 32'(timeout_o), 32'h0);

        // Grantee 3 drops its request
        do_reset();
        step(8'h08, 1'b0);
        chk("drop_idx3", 32'(grant_idx_o), 32'h3);
        step(8'h28, 1'b0);
        step(8'h28, 1'b0);
        step(8'h20, 1'b0);
        chk("drop_next5", 32'(grant_idx_o), 32'h5);
        step(8'h20, 1'b0);
        step(8'h00, 1'b0);
        chk("drop_to_idle", 32'(grant_valid_o), 32'h0);

        // Reset while index 5 is granted
        do_reset();
        step(8'h20, 1'b0);
        step(8'h20, 1'b0);
        chk("pre_rst_idx5", 32'(grant_idx_o), 32'h5);
        do_reset();
        step(8'hFF, 1'b0);
        chk("post_rst_idx0", 32'(grant_idx_o), 32'h0);

        // Randomised traffic
        do_reset();
        rv = N'($urandom);
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 3) == 0) rv = N'($urandom);
            if ($urandom_range(0, 7) == 0) rv = '0;
            step(rv, $urandom_range(0, 5) == 0);
            if (k == 400) do_reset();
        end

        repeat (3) @(negedge clk_i);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
